sin_src_dds: RTL

Clocked, multi-channel real-number sine source built around a phase accumulator (DDS style). It generalises the free-running sine source with a programmable frequency tuning word, per-channel phase offsets, a latched amplitude, and continuous or N-cycle burst modes. It drives `real` analog-model nets in mixed-signal testbenches, and its outputs update only on `clk`.

---
 rtl/sin_src_dds.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sin_src_dds.sv
// Multi-channel real-valued sine source driven by a phase accumulator.
// Supports continuous output or bursts of a programmed number of full periods.
module sin_src_dds #(
  parameter int               NCH     = 4,
  parameter int               PHASE_W = 32,
  parameter int               BURST_W = 16,
  parameter logic [PHASE_W-1:0] FTW_DEF = PHASE_W'(1) << (PHASE_W - 4),
  parameter real              AMP_DEF = 1.0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   start,
  input  logic                   mode,
  input  logic                   load,
  input  logic [PHASE_W-1:0]     ftw,
  input  real                    amp,
  input  logic [NCH*PHASE_W-1:0] ph_off,
  input  logic [BURST_W-1:0]     burst_len,
  output real                    out [NCH],
  output logic                   busy,
  output logic                   done,
  output logic                   wrap,
  output logic [1:0]             state_dbg
);

  localparam real TWO_PI     = 6.283185307179586;
  localparam real PHASE_SPAN = 2.0 ** PHASE_W;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   acc;
  logic [PHASE_W-1:0]   ftw_q;
  logic [PHASE_W-1:0]   off_q [NCH];
  real                  amp_q;
  logic [BURST_W-1:0]   cnt;
  logic [BURST_W-1:0]   len_q;
  logic                 mode_q;
  logic [PHASE_W:0]     sum;
  logic                 carry;
  logic                 last;

  function automatic real sample(input logic [PHASE_W-1:0] p, input real a);
    return a * $sin(TWO_PI * real'({1'b0, p}) / PHASE_SPAN);
  endfunction

  always_comb begin
    sum   = {1'b0, acc} + {1'b0, ftw_q};
    carry = sum[PHASE_W];
    // len_q is never 0 here: a zero-length burst skips RUN entirely.
    last  = mode_q && carry && (cnt == len_q - BURST_W'(1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && en) state_d = (mode && (burst_len == '0)) ? DONE : RUN;
      end
      RUN: begin
        if (!en)       state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      ftw_q   <= FTW_DEF;
      amp_q   <= AMP_DEF;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        off_q[k] <= '0;
        out[k]   <= 0.0;
      end
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
      wrap    <= 1'b0;

      // Working registers update after this edge's sample is computed.
      if (load) begin
        ftw_q <= ftw;
        amp_q <= amp;
        for (int k = 0; k < NCH; k++) off_q[k] <= ph_off[k*PHASE_W +: PHASE_W];
      end

      case (state_q)
        RUN: begin
          wrap <= carry;
          if (mode_q && carry) cnt <= cnt + BURST_W'(1);
          if (state_d == RUN) begin
            acc <= sum[PHASE_W-1:0];
            for (int k = 0; k < NCH; k++) out[k] <= sample(acc + off_q[k], amp_q);
          end else begin
            acc <= '0;
            for (int k = 0; k < NCH; k++) out[k] <= 0.0;
          end
        end
        default: begin
          acc <= '0;
          for (int k = 0; k < NCH; k++) out[k] <= 0.0;
          if (state_q == IDLE && start && en) begin
            cnt    <= '0;
            len_q  <= burst_len;
            mode_q <= mode;
          end
        end
      endcase
    end
  end

endmodule
